// File: rtl/alpha_blend_pipe_if.sv
// rtl/alpha_blend_pipe_if.sv - pixel stream and framebuffer bus for the alpha blender
interface alpha_blend_pipe_if #(
  parameter int CW  = 8,
  parameter int NCH = 3,
  parameter int AW  = 19
);
  logic                pixel_valid;
  logic                pixel_ready;
  logic [AW-1:0]       pixel_number;
  logic [NCH*CW-1:0]   src_rgb;
  logic [CW-1:0]       src_a;
  logic [1:0]          mode;
  logic                frame_ready;
  logic                read;
  logic [AW-1:0]       read_addr;
  logic [NCH*CW-1:0]   read_data;
  logic                write;
  logic [AW-1:0]       write_addr;
  logic [NCH*CW-1:0]   write_data;
  logic                o_frame_ready;
  logic                busy;

  modport slave (
    input  pixel_valid, pixel_number, src_rgb, src_a, mode, frame_ready, read_data,
    output pixel_ready, read, read_addr, write, write_addr, write_data, o_frame_ready, busy
  );

  modport master (
    output pixel_valid, pixel_number, src_rgb, src_a, mode, frame_ready, read_data,
    input  pixel_ready, read, read_addr, write, write_addr, write_data, o_frame_ready, busy
  );
endinterface

// File: rtl/alpha_blend_pipe.sv
// rtl/alpha_blend_pipe.sv - pipelined read-modify-write framebuffer blender
module alpha_blend_pipe #(
  parameter int CW     = 8,
  parameter int NCH    = 3,
  parameter int AW     = 19,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  alpha_blend_pipe_if.slave bus
);
  localparam int DW = NCH * CW;
  localparam int NS = RD_LAT + 1;
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [1:0] M_ALPHA   = 2'd0;
  localparam logic [1:0] M_ADD     = 2'd1;
  localparam logic [1:0] M_MULT    = 2'd2;
  localparam logic [1:0] M_REPLACE = 2'd3;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] src;
    logic [CW-1:0] a;
    logic [1:0]    mode;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        st [NS];
  entry_t        new_entry;
  logic          hazard, stages_busy, ready, accept, done;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] blend_data;

  function automatic logic [CW-1:0] blend_ch(input logic [1:0] m, input logic [CW-1:0] s,
                                             input logic [CW-1:0] d, input logic [CW-1:0] a);
    logic [2*CW-1:0] sw, dw, aw, iw, acc;
    logic [CW:0]     sum;
    sw  = {{CW{1'b0}}, s};
    dw  = {{CW{1'b0}}, d};
    aw  = {{CW{1'b0}}, a};
    iw  = {{CW{1'b0}}, MAX - a};
    acc = '0;
    sum = '0;
    blend_ch = s;
    case (m)
      M_ALPHA: begin
        if (a == MAX) blend_ch = s;
        else if (a == '0) blend_ch = d;
        else begin
          acc      = aw * sw + iw * dw;
          blend_ch = CW'(acc >> CW);
        end
      end
      M_ADD: begin
        sum      = {1'b0, s} + {1'b0, d};
        blend_ch = sum[CW] ? MAX : sum[CW-1:0];
      end
      M_MULT: begin
        acc      = sw * dw;
        blend_ch = CW'(acc >> CW);
      end
      default: blend_ch = s;
    endcase
  endfunction

  // The write-stage entry is not in st[], so a same-address pixel may enter as it writes.
  always_comb begin
    hazard      = 1'b0;
    stages_busy = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (st[k].valid) begin
        stages_busy = 1'b1;
        if (st[k].addr == bus.pixel_number) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        ready = !hazard;
        if (bus.frame_ready) state_nxt = DRAIN;
      end
      DRAIN: if (!stages_busy) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  assign accept    = bus.pixel_valid && ready && !reset;
  assign new_entry = '{valid: 1'b1, addr: bus.pixel_number, src: bus.src_rgb,
                       a: bus.src_a, mode: bus.mode};

  always_comb begin
    blend_data = '0;
    for (int c = 0; c < NCH; c++) begin
      blend_data[c*CW +: CW] = blend_ch(st[NS-1].mode, st[NS-1].src[c*CW +: CW],
                                        bus.read_data[c*CW +: CW], st[NS-1].a);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) st[k] <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      st[0] <= accept ? new_entry : '0;
      for (int k = 1; k < NS; k++) st[k] <= st[k-1];
      wr_valid <= st[NS-1].valid;
      if (st[NS-1].valid) begin
        wr_addr <= st[NS-1].addr;
        wr_data <= blend_data;
      end
    end
  end

  assign bus.pixel_ready   = ready && !reset;
  assign bus.read          = st[0].valid && (st[0].mode != M_REPLACE);
  assign bus.read_addr     = st[0].addr;
  assign bus.write         = wr_valid;
  assign bus.write_addr    = wr_addr;
  assign bus.write_data    = wr_data;
  assign bus.o_frame_ready = done;
  assign bus.busy          = stages_busy || wr_valid || (state != RUN);
endmodule

// File: tb/tb_alpha_blend_pipe.sv
// tb/tb_alpha_blend_pipe.sv - directed-vector bench for alpha_blend_pipe
module tb_alpha_blend_pipe;
  localparam int CW = 8, NCH = 3, AW = 8, RD_LAT = 2, DW = 24, HN = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alpha_blend_pipe_if #(.CW(CW), .NCH(NCH), .AW(AW)) bus ();
  alpha_blend_pipe #(.CW(CW), .NCH(NCH), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // framebuffer with two-cycle read latency
  logic [DW-1:0] fb [256];
  logic          d1v = 1'b0, d2v = 1'b0;
  logic [AW-1:0] d1a = '0, d2a = '0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  always @(posedge clk) begin
    d1v <= bus.read;
    d1a <= bus.read_addr;
    d2v <= d1v;
    d2a <= d1a;
    if (bus.write) fb[bus.write_addr] <= bus.write_data;
    if (pre_we) fb[pre_a] <= pre_d;
  end
  assign bus.read_data = d2v ? fb[d2a] : '0;

  logic          wr_v [HN];
  logic [AW-1:0] wr_a [HN];
  logic [DW-1:0] wr_d [HN];
  logic          rd_v [HN];
  logic [AW-1:0] rd_a [HN];
  logic          ofr_v [HN];
  logic          rdy_v [HN];
  logic          busy_v [HN];
  always @(negedge clk) begin
    if (cyc < HN) begin
      wr_v[cyc]   <= bus.write;
      wr_a[cyc]   <= bus.write_addr;
      wr_d[cyc]   <= bus.write_data;
      rd_v[cyc]   <= bus.read;
      rd_a[cyc]   <= bus.read_addr;
      ofr_v[cyc]  <= bus.o_frame_ready;
      rdy_v[cyc]  <= bus.pixel_ready;
      busy_v[cyc] <= bus.busy;
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {b, g, r};
  endfunction

  function automatic int count_hits(input int which, input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) begin
      if (which == 0 && wr_v[i] === 1'b1) n++;
      if (which == 1 && rd_v[i] === 1'b1) n++;
      if (which == 2 && ofr_v[i] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] s, input logic [7:0] al,
                      input logic [1:0] m, input logic fr, output int t);
    int n = 0;
    bus.pixel_valid = 1'b1; bus.pixel_number = a; bus.src_rgb = s;
    bus.src_a = al; bus.mode = m; bus.frame_ready = fr;
    @(negedge clk);
    while (bus.pixel_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    t = cyc;
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0; bus.frame_ready = 1'b0;
  endtask

  int t, t1, t2, t3;

  initial begin
    bus.pixel_valid = 1'b0; bus.pixel_number = '0; bus.src_rgb = '0;
    bus.src_a = '0; bus.mode = '0; bus.frame_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.pixel_ready, 0);
    check("rst_read", bus.read, 0);
    check("rst_write", bus.write, 0);
    check("rst_ofr", bus.o_frame_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_waddr", bus.write_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.pixel_ready, 1);
    @(posedge clk); #1;

    preload(10, rgb(8'h01, 8'h02, 8'h03));
    preload(11, rgb(8'h33, 8'h33, 8'h33));
    preload(12, rgb(8'hFF, 8'hAA, 8'h00));
    preload(13, rgb(8'h20, 8'h10, 8'h00));
    preload(14, rgb(8'hFF, 8'h80, 8'hFF));

    send(10, rgb(8'h80, 8'h40, 8'hC0), 8'h11, 2'd0, 1'b0, t);
    idle(8);
    check("alpha_read", rd_v[t+1], 1);
    check("alpha_raddr", rd_a[t+1], 10);
    check("alpha_wr", wr_v[t+4], 1);
    check("alpha_waddr", wr_a[t+4], 10);
    check("alpha_data", wr_d[t+4], rgb(8'h09, 8'h06, 8'h0F));
    check("alpha_nwr", count_hits(0, t, t+8), 1);

    send(11, rgb(8'h80, 8'h40, 8'hC0), 8'hFF, 2'd0, 1'b0, t);
    idle(8);
    check("alpha_ff", wr_d[t+4], rgb(8'h80, 8'h40, 8'hC0));
    send(12, rgb(8'h12, 8'h34, 8'h56), 8'h00, 2'd0, 1'b0, t);
    idle(8);
    check("alpha_00", wr_d[t+4], rgb(8'hFF, 8'hAA, 8'h00));

    send(13, rgb(8'hF0, 8'h10, 8'h00), 8'h00, 2'd1, 1'b0, t);
    idle(8);
    check("add_sat", wr_d[t+4], rgb(8'hFF, 8'h20, 8'h00));
    send(14, rgb(8'hFF, 8'h80, 8'h00), 8'h00, 2'd2, 1'b0, t);
    idle(8);
    check("mult", wr_d[t+4], rgb(8'hFE, 8'h40, 8'h00));

    send(15, rgb(8'h12, 8'h34, 8'h56), 8'h00, 2'd3, 1'b0, t);
    idle(8);
    check("repl_noread", count_hits(1, t, t+8), 0);
    check("repl_wr", wr_v[t+4], 1);
    check("repl_data", wr_d[t+4], rgb(8'h12, 8'h34, 8'h56));

    send(1, rgb(8'h01, 8'h00, 8'h00), 8'h00, 2'd3, 1'b0, t1);
    send(2, rgb(8'h02, 8'h00, 8'h00), 8'h00, 2'd3, 1'b0, t2);
    send(3, rgb(8'h03, 8'h00, 8'h00), 8'h00, 2'd3, 1'b0, t3);
    idle(8);
    check("stream_t2", 32'(t2 - t1), 1);
    check("stream_t3", 32'(t3 - t1), 2);
    for (int i = 0; i < 3; i++) begin
      check("stream_wr", wr_v[t1+4+i], 1);
      check("stream_addr", wr_a[t1+4+i], 32'(i + 1));
    end

    send(5, rgb(8'h10, 8'h20, 8'h30), 8'h00, 2'd3, 1'b0, t1);
    send(5, rgb(8'h01, 8'h01, 8'h01), 8'h00, 2'd1, 1'b0, t2);
    idle(10);
    check("haz_gap", 32'(t2 - t1), 4);
    for (int i = 1; i <= 3; i++) check("haz_rdy_low", rdy_v[t1+i], 0);
    check("haz_wr1", wr_v[t1+4], 1);
    check("haz_read", rd_v[t1+5], 1);
    check("haz_wr2", wr_v[t1+8], 1);
    check("haz_data", wr_d[t1+8], rgb(8'h11, 8'h21, 8'h31));

    send(20, rgb(8'h44, 8'h55, 8'h66), 8'h00, 2'd3, 1'b1, t);
    idle(10);
    check("frm_rdy_low", rdy_v[t+1], 0);
    check("frm_busy", busy_v[t+2], 1);
    check("frm_wr", wr_v[t+4], 1);
    check("frm_ofr", ofr_v[t+5], 1);
    check("frm_ofr_cnt", count_hits(2, t, t+10), 1);
    check("frm_rdy_back", rdy_v[t+6], 1);

    send(30, rgb(8'hAA, 8'hBB, 8'hCC), 8'h00, 2'd3, 1'b0, t);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mrst_write", bus.write, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_ready", bus.pixel_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(8);
    check("mrst_nwr", count_hits(0, t, t+10), 0);
    check("mrst_nofr", count_hits(2, t, t+10), 0);
    check("mrst_wdata", bus.write_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
